// File: rtl/bcd_seg_timer_pkg.sv
// Shared seven-segment helpers for the BCD timer.
// Exports SEG_BLANK, seg7_decode() and the bcd_of() constant builder.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg7_decode = 7'h3f;
      4'd1:    seg7_decode = 7'h06;
      4'd2:    seg7_decode = 7'h5b;
      4'd3:    seg7_decode = 7'h4f;
      4'd4:    seg7_decode = 7'h66;
      4'd5:    seg7_decode = 7'h6d;
      4'd6:    seg7_decode = 7'h7d;
      4'd7:    seg7_decode = 7'h07;
      4'd8:    seg7_decode = 7'h7f;
      4'd9:    seg7_decode = 7'h6f;
      default: seg7_decode = SEG_BLANK;
    endcase
  endfunction

  // Six-digit BCD image of an integer, for elaboration-time constants.
  function automatic logic [23:0] bcd_of(input int unsigned v);
    int unsigned r;
    r = v;
    bcd_of = '0;
    for (int k = 0; k < 6; k++) begin
      bcd_of[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

endpackage

// File: rtl/bcd_seg_timer_if.sv
// Control and display bundle of the BCD timer.
// master: board side (buttons/switches), slave: timer.
interface bcd_seg_timer_if #(
  parameter int DIGITS = 2
);
  logic                  hold_btn;
  logic                  clr;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic [9*DIGITS-1:0]   seg_led;
  logic                  running;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output hold_btn, clr, up_dn, load, load_val,
    input  bcd, seg_led, running, wrap, load_err
  );

  modport slave (
    input  hold_btn, clr, up_dn, load, load_val,
    output bcd, seg_led, running, wrap, load_err
  );
endinterface

// File: rtl/bcd_seg_timer_hold_debounce.sv
// Button conditioner: 2-FF sync, DB_CYCLES debounce, rise pulse.
// Ports: clk, rst (sync, active-low), btn (raw), rise (1-cycle).
module hold_debounce #(
  parameter int DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_TOP = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == C_TOP) begin
        lvl  <= s2;
        cnt  <= '0;
        rise <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_seg_timer.sv
// Multi-digit BCD up/down timer with load, clear, pause, 7-seg out.
// Ports: clk, rst (sync, active-low), io (bcd_seg_timer_if.slave).
module bcd_seg_timer
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int TICK_HZ   = 1,
  parameter int DIGITS    = 2,
  parameter int MODULUS   = 24,
  parameter int DB_CYCLES = 240000,
  parameter int BLANK_LZ  = 0
) (
  input logic            clk,
  input logic            rst,
  bcd_seg_timer_if.slave io
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int W   = 4 * DIGITS;
  localparam int SW  = 9 * DIGITS;

  localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
  localparam logic [23:0]   MAX24   = bcd_of(MODULUS - 1);
  localparam logic [W-1:0]  MAX_BCD = MAX24[W-1:0];

  function automatic logic [SW-1:0] seg_of(input logic [W-1:0] v);
    logic       lz;
    logic [3:0] d;
    seg_of = '0;
    lz     = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d  = v[4*k +: 4];
      lz = lz && (d == 4'd0);
      if (BLANK_LZ != 0 && k != 0 && lz)
        seg_of[9*k +: 9] = {2'b00, SEG_BLANK};
      else
        seg_of[9*k +: 9] = {2'b00, seg7_decode(d)};
    end
  endfunction

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [W-1:0]  cnt;
  logic [SW-1:0] seg_q;
  logic          run_q;
  logic          wrap_q;
  logic          lerr_q;
  logic          tick;
  logic          db_rise;
  logic          ld_ok;
  logic [W-1:0]  inc_v;
  logic [W-1:0]  dec_v;
  logic [W-1:0]  nxt;
  logic          nwrap;

  hold_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .btn  (io.hold_btn),
    .rise (db_rise)
  );

  assign tick    = run_q && (pre == PRE_TOP);
  assign pre_nxt = (pre == PRE_TOP) ? '0 : pre + 1'b1;

  always_comb begin : p_ld
    ld_ok = (io.load_val <= MAX_BCD);
    for (int k = 0; k < DIGITS; k++)
      if (io.load_val[4*k +: 4] > 4'd9)
        ld_ok = 1'b0;
  end

  // Digit-wise carry/borrow ripple; only 0..9 ever reaches a register.
  always_comb begin : p_step
    logic cy;
    logic bw;
    inc_v = cnt;
    dec_v = cnt;
    cy    = 1'b1;
    bw    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (cy) begin
        if (cnt[4*k +: 4] == 4'd9) begin
          inc_v[4*k +: 4] = 4'd0;
        end else begin
          inc_v[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (cnt[4*k +: 4] == 4'd0) begin
          dec_v[4*k +: 4] = 4'd9;
        end else begin
          dec_v[4*k +: 4] = cnt[4*k +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (io.up_dn) begin
      nwrap = (cnt == MAX_BCD);
      nxt   = nwrap ? '0 : inc_v;
    end else begin
      nwrap = (cnt == '0);
      nxt   = nwrap ? MAX_BCD : dec_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre    <= '0;
      cnt    <= '0;
      seg_q  <= seg_of('0);
      run_q  <= 1'b1;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
      seg_q  <= seg_of(cnt);
      if (db_rise)
        run_q <= ~run_q;
      if (io.clr) begin
        cnt <= '0;
        pre <= '0;
      end else if (io.load) begin
        // A load strobe always swallows the tick, even when rejected.
        if (ld_ok) begin
          cnt <= io.load_val;
          pre <= '0;
        end else begin
          lerr_q <= 1'b1;
          if (run_q)
            pre <= pre_nxt;
        end
      end else if (run_q) begin
        pre <= pre_nxt;
        if (tick) begin
          cnt    <= nxt;
          wrap_q <= nwrap;
        end
      end
    end
  end

  assign io.bcd      = cnt;
  assign io.seg_led  = seg_q;
  assign io.running  = run_q;
  assign io.wrap     = wrap_q;
  assign io.load_err = lerr_q;
endmodule

// File: tb/tb_bcd_seg_timer.sv
// Bench for bcd_seg_timer: two configurations vs an integer model.
// Directed scenarios followed by randomized control traffic.
module tb_bcd_seg_timer;
  localparam int DIV = 10;
  localparam int DB  = 4;

  logic clk;
  logic rst;

  bcd_seg_timer_if #(.DIGITS(2)) if0 ();
  bcd_seg_timer_if #(.DIGITS(3)) if1 ();

  bcd_seg_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULUS(24),
    .DB_CYCLES(DB), .BLANK_LZ(0)
  ) dut0 (
    .clk(clk), .rst(rst), .io(if0.slave)
  );

  bcd_seg_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(3), .MODULUS(1000),
    .DB_CYCLES(DB), .BLANK_LZ(1)
  ) dut1 (
    .clk(clk), .rst(rst), .io(if1.slave)
  );

  bit c_clr[2];
  bit c_up[2];
  bit c_ld[2];
  int c_lv[2];
  bit c_btn[2];

  assign if0.clr      = c_clr[0];
  assign if0.up_dn    = c_up[0];
  assign if0.load     = c_ld[0];
  assign if0.load_val = 8'(c_lv[0]);
  assign if0.hold_btn = c_btn[0];
  assign if1.clr      = c_clr[1];
  assign if1.up_dn    = c_up[1];
  assign if1.load     = c_ld[1];
  assign if1.load_val = 12'(c_lv[1]);
  assign if1.hold_btn = c_btn[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int md[2] = '{24, 1000};
  int nd[2] = '{2, 3};
  bit bl[2] = '{1'b0, 1'b1};
  int tbl[10] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66,
                  'h6d, 'h7d, 'h07, 'h7f, 'h6f};

  int m_cnt[2];
  int m_ph[2];
  int m_seg[2];
  bit m_run[2];
  bit m_wrap[2];
  bit m_lerr[2];
  bit m_db[2];
  bit m_pend[2];
  bit hist[2][16];

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int to_bcd(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 6; k++) begin
      r |= (v % 10) << (4 * k);
      v /= 10;
    end
    return r;
  endfunction

  function automatic int segs(input int v, input int n, input bit b);
    int r;
    int pw;
    r  = 0;
    pw = 1;
    for (int k = 0; k < n; k++) begin
      if (!(b && k > 0 && v < pw))
        r |= tbl[(v / pw) % 10] << (9 * k);
      pw *= 10;
    end
    return r;
  endfunction

  task automatic m_reset(input int i);
    m_cnt[i]  = 0;
    m_ph[i]   = 0;
    m_seg[i]  = segs(0, nd[i], bl[i]);
    m_run[i]  = 1'b1;
    m_wrap[i] = 1'b0;
    m_lerr[i] = 1'b0;
    m_db[i]   = 1'b0;
    m_pend[i] = 1'b0;
    for (int k = 0; k < 16; k++) hist[i][k] = 1'b0;
  endtask

  task automatic step(input int i);
    bit tk;
    bit ok;
    bit acc;
    bit v;
    int lvd;
    int pw;
    int nib;
    if (!rst) begin
      m_reset(i);
      return;
    end
    tk = m_run[i] && m_ph[i] == DIV - 1;
    m_seg[i]  = segs(m_cnt[i], nd[i], bl[i]);
    m_wrap[i] = 1'b0;
    m_lerr[i] = 1'b0;
    if (c_clr[i]) begin
      m_cnt[i] = 0;
      m_ph[i]  = 0;
    end else if (c_ld[i]) begin
      ok  = 1'b1;
      lvd = 0;
      pw  = 1;
      for (int k = 0; k < nd[i]; k++) begin
        nib = (c_lv[i] >> (4 * k)) & 15;
        if (nib > 9) ok = 1'b0;
        lvd += nib * pw;
        pw  *= 10;
      end
      if (ok && lvd < md[i]) begin
        m_cnt[i] = lvd;
        m_ph[i]  = 0;
      end else begin
        m_lerr[i] = 1'b1;
        if (m_run[i]) m_ph[i] = (m_ph[i] + 1) % DIV;
      end
    end else if (m_run[i]) begin
      m_ph[i] = (m_ph[i] + 1) % DIV;
      if (tk) begin
        if (c_up[i]) begin
          m_wrap[i] = (m_cnt[i] == md[i] - 1);
          m_cnt[i]  = (m_cnt[i] + 1) % md[i];
        end else begin
          m_wrap[i] = (m_cnt[i] == 0);
          m_cnt[i]  = (m_cnt[i] + md[i] - 1) % md[i];
        end
      end
    end
    // Pause: accepted level = last DB synchronised samples all agree.
    if (m_pend[i]) m_run[i] = !m_run[i];
    for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = c_btn[i];
    v   = hist[i][2];
    acc = (v != m_db[i]);
    for (int k = 2; k < DB + 2; k++)
      if (hist[i][k] != v) acc = 1'b0;
    m_pend[i] = acc && v;
    if (acc) m_db[i] = v;
  endtask

  task automatic look(input int i);
    int gb;
    int gs;
    int gr;
    int gw;
    int ge;
    if (i == 0) begin
      gb = int'(if0.bcd);     gs = int'(if0.seg_led);
      gr = int'(if0.running); gw = int'(if0.wrap);
      ge = int'(if0.load_err);
    end else begin
      gb = int'(if1.bcd);     gs = int'(if1.seg_led);
      gr = int'(if1.running); gw = int'(if1.wrap);
      ge = int'(if1.load_err);
    end
    chk($sformatf("bcd%0d", i), gb, to_bcd(m_cnt[i]));
    chk($sformatf("seg%0d", i), gs, m_seg[i]);
    chk($sformatf("running%0d", i), gr, int'(m_run[i]));
    chk($sformatf("wrap%0d", i), gw, int'(m_wrap[i]));
    chk($sformatf("load_err%0d", i), ge, int'(m_lerr[i]));
  endtask

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      step(0);
      step(1);
      @(negedge clk);
      look(0);
      look(1);
      c_clr = '{1'b0, 1'b0};
      c_ld  = '{1'b0, 1'b0};
    end
  endtask

  task automatic press(input int len);
    c_btn = '{1'b1, 1'b1};
    cyc(len);
    c_btn = '{1'b0, 1'b0};
  endtask

  initial begin
    bit found;
    int msk;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    c_up   = '{1'b1, 1'b1};
    c_lv   = '{0, 0};
    c_btn  = '{1'b0, 1'b0};
    c_clr  = '{1'b0, 1'b0};
    c_ld   = '{1'b0, 1'b0};
    m_reset(0);
    m_reset(1);
    cyc(3);
    rst = 1'b1;
    cyc(260);

    c_clr = '{1'b1, 1'b1};
    cyc(1);
    c_up = '{1'b0, 1'b0};
    cyc(25);

    c_up = '{1'b1, 1'b1};
    c_ld = '{1'b1, 1'b1};
    c_lv = '{'h19, 'h009};
    cyc(5);
    c_ld[0] = 1'b1; c_lv[0] = 'h24;
    cyc(3);
    c_ld[0] = 1'b1; c_lv[0] = 'h1a;
    cyc(3);
    c_ld[1] = 1'b1; c_lv[1] = 'h9a9;
    cyc(15);

    press(3);
    cyc(10);
    press(8);
    cyc(30);
    press(8);
    cyc(40);

    found = 1'b0;
    for (int j = 0; j < 3 * DIV && !found; j++) begin
      if (m_run[0] && m_ph[0] == DIV - 1) begin
        c_clr[0] = 1'b1;
        found = 1'b1;
      end
      cyc(1);
    end
    chk("clr_tick_found", int'(found), 1);
    cyc(35);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(12);

    for (int j = 0; j < 1500; j++) begin
      rst = ($urandom % 400 != 0);
      for (int i = 0; i < 2; i++) begin
        msk = (1 << (4 * nd[i])) - 1;
        c_clr[i] = ($urandom % 97 == 0);
        c_ld[i]  = ($urandom % 23 == 0);
        if ($urandom % 2 != 0)
          c_lv[i] = to_bcd($urandom_range(0, md[i] + 5)) & msk;
        else
          c_lv[i] = $urandom & msk;
        if ($urandom % 50 == 0) c_up[i] = !c_up[i];
        if ($urandom % 12 == 0) c_btn[i] = !c_btn[i];
      end
      cyc(1);
    end
    rst = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
